// File: rtl/passcode_pkg.sv
// Shared types and sizing helpers for the passcode lockout controller.
package passcode_pkg;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    ENTRY   = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } lock_state_t;

  localparam int DEF_MAX_FAILS     = 3;
  localparam int DEF_ENTRY_TIMEOUT = 20;
  localparam int DEF_UNLOCK_CYCLES = 30;
  localparam int DEF_LOCK_CYCLES   = 50;

  function automatic int fail_cnt_w(input int max_fails);
    return $clog2(max_fails + 1);
  endfunction

  // A timer loaded with N-1 needs only enough bits to hold N-1.
  function automatic int timer_w(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter: expire is high during the cycle the count reads zero,
// after which the timer idles until the next load.
module cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_r;
  logic         run_r;

  // count down from the loaded value and stop once zero has been seen
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
      run_r <= 1'b0;
    end else if (load) begin
      cnt_r <= load_val;
      run_r <= 1'b1;
    end else if (run_r) begin
      if (cnt_r == {W{1'b0}}) begin
        run_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r - W'(1'b1);
      end
    end else begin
      cnt_r <= cnt_r;
      run_r <= run_r;
    end
  end

  assign expire = run_r && (cnt_r == {W{1'b0}});

endmodule

// File: rtl/passcode_lockout_ctrl.sv
// Entry sequencing, failure counting and lockout for the passcode datapath.
// Optional PASSCODE_ALARM_EN adds a sticky Alarm output set on lockout entry.
module passcode_lockout_ctrl
  import passcode_pkg::*;
#(
  parameter int MAX_FAILS     = DEF_MAX_FAILS,
  parameter int ENTRY_TIMEOUT = DEF_ENTRY_TIMEOUT,
  parameter int UNLOCK_CYCLES = DEF_UNLOCK_CYCLES,
  parameter int LOCK_CYCLES   = DEF_LOCK_CYCLES
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic [2:0]                          Peff,
  input  logic                                P2,
  input  logic                                P1,
  output logic [2:0]                          Pgate,
  output logic                                Pclr,
  output logic                                Unlocked,
  output logic                                Locked,
`ifdef PASSCODE_ALARM_EN
  output logic                                Alarm,
`endif
  output logic [fail_cnt_w(MAX_FAILS)-1:0]    FailCnt
);

  localparam int FW  = fail_cnt_w(MAX_FAILS);
  localparam int FW1 = FW + 1;
  localparam int EW  = timer_w(ENTRY_TIMEOUT);
  localparam int UW  = timer_w(UNLOCK_CYCLES);
  localparam int LW  = timer_w(LOCK_CYCLES);

  localparam logic [FW:0]   MAX_FAILS_V = FW1'(MAX_FAILS);
  localparam logic [EW-1:0] ENTRY_LOAD  = EW'(ENTRY_TIMEOUT - 1);
  localparam logic [UW-1:0] UNLOCK_LOAD = UW'(UNLOCK_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LOAD   = LW'(LOCK_CYCLES - 1);

  lock_state_t   state_r;
  lock_state_t   state_nxt_s;
  logic [2:0]    pgate_nxt_s;
  logic          pclr_nxt_s;
  logic [FW-1:0] fail_nxt_s;
  logic [FW:0]   fail_inc_s;
  logic          press_s;
  logic          entry_load_s;
  logic          unlock_load_s;
  logic          lock_load_s;
  logic          entry_exp_s;
  logic          unlock_exp_s;
  logic          lock_exp_s;

  assign press_s    = (Peff != 3'b000);
  assign fail_inc_s = {1'b0, FailCnt} + FW1'(1'b1);

  cycle_timer #(.W(EW)) u_entry_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (entry_load_s),
    .load_val (ENTRY_LOAD),
    .expire   (entry_exp_s)
  );

  cycle_timer #(.W(UW)) u_unlock_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (unlock_load_s),
    .load_val (UNLOCK_LOAD),
    .expire   (unlock_exp_s)
  );

  cycle_timer #(.W(LW)) u_lock_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (lock_load_s),
    .load_val (LOCK_LOAD),
    .expire   (lock_exp_s)
  );

  // state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ARMED;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next state, forwarded presses, clear pulse and failure count
  always_comb begin
    state_nxt_s   = state_r;
    pgate_nxt_s   = 3'b000;
    pclr_nxt_s    = 1'b0;
    fail_nxt_s    = FailCnt;
    entry_load_s  = 1'b0;
    unlock_load_s = 1'b0;
    lock_load_s   = 1'b0;
    case (state_r)
      ARMED: begin
        if (press_s) begin
          state_nxt_s  = ENTRY;
          pgate_nxt_s  = Peff;
          entry_load_s = 1'b1;
        end else begin
          state_nxt_s = ARMED;
        end
      end
      ENTRY: begin
        // P1 beats P2; P2 and any press beat a timeout; a result drops the press
        if (P1 || (!P2 && !press_s && entry_exp_s)) begin
          pclr_nxt_s = 1'b1;
          if (fail_inc_s >= MAX_FAILS_V) begin
            state_nxt_s = LOCKOUT;
            lock_load_s = 1'b1;
            fail_nxt_s  = MAX_FAILS_V[FW-1:0];
          end else begin
            state_nxt_s = ARMED;
            fail_nxt_s  = fail_inc_s[FW-1:0];
          end
        end else if (P2) begin
          state_nxt_s   = OPEN;
          pclr_nxt_s    = 1'b1;
          unlock_load_s = 1'b1;
          fail_nxt_s    = {FW{1'b0}};
        end else if (press_s) begin
          pgate_nxt_s  = Peff;
          entry_load_s = 1'b1;
        end else begin
          state_nxt_s = ENTRY;
        end
      end
      OPEN: begin
        if (unlock_exp_s) begin
          state_nxt_s = ARMED;
          pclr_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = OPEN;
        end
      end
      LOCKOUT: begin
        if (lock_exp_s) begin
          state_nxt_s = ARMED;
          pclr_nxt_s  = 1'b1;
          fail_nxt_s  = {FW{1'b0}};
        end else begin
          state_nxt_s = LOCKOUT;
        end
      end
      default: begin
        state_nxt_s = ARMED;
      end
    endcase
  end

  // registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      Pgate    <= 3'b000;
      Pclr     <= 1'b0;
      Unlocked <= 1'b0;
      Locked   <= 1'b0;
      FailCnt  <= {FW{1'b0}};
    end else begin
      Pgate    <= pgate_nxt_s;
      Pclr     <= pclr_nxt_s;
      Unlocked <= (state_nxt_s == OPEN);
      Locked   <= (state_nxt_s == LOCKOUT);
      FailCnt  <= fail_nxt_s;
    end
  end

`ifdef PASSCODE_ALARM_EN
  // sticky alarm, cleared only by reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      Alarm <= 1'b0;
    end else if (lock_load_s) begin
      Alarm <= 1'b1;
    end else begin
      Alarm <= Alarm;
    end
  end
`endif

endmodule

// File: tb/tb_passcode_lockout_ctrl.sv
// Directed self-checking bench for passcode_lockout_ctrl
// (MAX_FAILS=3, ENTRY_TIMEOUT=6, UNLOCK_CYCLES=5, LOCK_CYCLES=8).
module tb_passcode_lockout_ctrl;

  logic       CLK;
  logic       RST;
  logic [2:0] Peff;
  logic       P2;
  logic       P1;
  logic [2:0] Pgate;
  logic       Pclr;
  logic       Unlocked;
  logic       Locked;
  logic [1:0] FailCnt;
`ifdef PASSCODE_ALARM_EN
  logic       Alarm;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  passcode_lockout_ctrl #(
    .MAX_FAILS     (3),
    .ENTRY_TIMEOUT (6),
    .UNLOCK_CYCLES (5),
    .LOCK_CYCLES   (8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Peff     (Peff),
    .P2       (P2),
    .P1       (P1),
    .Pgate    (Pgate),
    .Pclr     (Pclr),
    .Unlocked (Unlocked),
    .Locked   (Locked),
`ifdef PASSCODE_ALARM_EN
    .Alarm    (Alarm),
`endif
    .FailCnt  (FailCnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [2:0] peff, input logic p1, input logic p2);
    Peff = peff;
    P1   = p1;
    P2   = p2;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] pg, input logic pc,
                         input logic ul, input logic lk, input logic [1:0] fc);
    chk({tag, ".Pgate"},    {5'd0, Pgate},    {5'd0, pg});
    chk({tag, ".Pclr"},     {7'd0, Pclr},     {7'd0, pc});
    chk({tag, ".Unlocked"}, {7'd0, Unlocked}, {7'd0, ul});
    chk({tag, ".Locked"},   {7'd0, Locked},   {7'd0, lk});
    chk({tag, ".FailCnt"},  {6'd0, FailCnt},  {6'd0, fc});
  endtask

  initial begin
    RST = 1'b1;
    drive(3'b000, 1'b0, 1'b0);
    tick();
    tick();
    chk_all("reset", 3'b000, 1'b0, 1'b0, 1'b0, 2'd0);
`ifdef PASSCODE_ALARM_EN
    chk("reset.Alarm", {7'd0, Alarm}, 8'd0);
`endif
    RST = 1'b0;

    // correct code 010, 001, 100 then P2
    drive(3'b010, 1'b0, 1'b0); tick();
    chk_all("cc_press1", 3'b010, 1'b0, 1'b0, 1'b0, 2'd0);
    drive(3'b000, 1'b0, 1'b0); tick();
    chk("cc_gap.Pgate", {5'd0, Pgate}, 8'd0);
    drive(3'b001, 1'b0, 1'b0); tick();
    chk("cc_press2.Pgate", {5'd0, Pgate}, 8'd1);
    drive(3'b100, 1'b0, 1'b0); tick();
    chk("cc_press3.Pgate", {5'd0, Pgate}, 8'd4);
    drive(3'b000, 1'b0, 1'b1); tick();
    chk_all("cc_open", 3'b000, 1'b1, 1'b1, 1'b0, 2'd0);
    for (int i = 1; i <= 5; i++) begin
      drive((i == 2) ? 3'b111 : 3'b000, 1'b0, 1'b0);
      tick();
      chk("cc_dwell.Unlocked", {7'd0, Unlocked}, (i < 5) ? 8'd1 : 8'd0);
      chk("cc_dwell.Pclr", {7'd0, Pclr}, (i == 5) ? 8'd1 : 8'd0);
      chk("cc_dwell.Pgate", {5'd0, Pgate}, 8'd0);
    end
    drive(3'b000, 1'b0, 1'b0); tick();
    chk_all("cc_after", 3'b000, 1'b0, 1'b0, 1'b0, 2'd0);

    // three wrong codes lead to lockout
    for (int k = 1; k <= 3; k++) begin
      drive(3'b001, 1'b0, 1'b0); tick();
      chk("fail_press.Pgate", {5'd0, Pgate}, 8'd1);
      drive(3'b000, 1'b1, 1'b0); tick();
      chk("fail.FailCnt", {6'd0, FailCnt}, 8'(k));
      chk("fail.Pclr", {7'd0, Pclr}, 8'd1);
      chk("fail.Locked", {7'd0, Locked}, (k == 3) ? 8'd1 : 8'd0);
    end
`ifdef PASSCODE_ALARM_EN
    chk("lockout.Alarm", {7'd0, Alarm}, 8'd1);
`endif
    for (int i = 1; i <= 8; i++) begin
      drive((i == 1) ? 3'b101 : 3'b000, 1'b0, 1'b0);
      tick();
      chk("lock_dwell.Locked", {7'd0, Locked}, (i < 8) ? 8'd1 : 8'd0);
      chk("lock_dwell.Pgate", {5'd0, Pgate}, 8'd0);
      chk("lock_dwell.Pclr", {7'd0, Pclr}, (i == 8) ? 8'd1 : 8'd0);
      chk("lock_dwell.FailCnt", {6'd0, FailCnt}, (i < 8) ? 8'd3 : 8'd0);
    end
    drive(3'b000, 1'b1, 1'b0); tick();
    chk_all("armed_p1_ignored", 3'b000, 1'b0, 1'b0, 1'b0, 2'd0);

    // entry timeout: one press then idle
    drive(3'b100, 1'b0, 1'b0); tick();
    chk("to_press.Pgate", {5'd0, Pgate}, 8'd4);
    drive(3'b000, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("to_wait.Pclr", {7'd0, Pclr}, (i == 6) ? 8'd1 : 8'd0);
      chk("to_wait.FailCnt", {6'd0, FailCnt}, (i == 6) ? 8'd1 : 8'd0);
    end
    // press on the timeout cycle reloads instead of failing
    drive(3'b010, 1'b0, 1'b0); tick();
    for (int i = 1; i <= 6; i++) begin
      drive((i == 6) ? 3'b001 : 3'b000, 1'b0, 1'b0);
      tick();
      chk("to_reload.Pclr", {7'd0, Pclr}, 8'd0);
      chk("to_reload.Pgate", {5'd0, Pgate}, (i == 6) ? 8'd1 : 8'd0);
    end
    chk("to_reload.FailCnt", {6'd0, FailCnt}, 8'd1);
    // P2 on the timeout cycle opens the lock
    for (int i = 1; i <= 6; i++) begin
      drive(3'b000, 1'b0, (i == 6));
      tick();
      if (i < 6) chk("to_p2_wait.Pclr", {7'd0, Pclr}, 8'd0);
    end
    chk_all("to_p2_open", 3'b000, 1'b1, 1'b1, 1'b0, 2'd0);
    drive(3'b000, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) tick();
    chk_all("to_p2_close", 3'b000, 1'b1, 1'b0, 1'b0, 2'd0);
`ifdef PASSCODE_ALARM_EN
    chk("unlock_after_lockout.Alarm", {7'd0, Alarm}, 8'd1);
`endif
    tick();

    // P1 and P2 together count as a failure
    drive(3'b001, 1'b0, 1'b0); tick();
    drive(3'b000, 1'b1, 1'b1); tick();
    chk_all("p1p2", 3'b000, 1'b1, 1'b0, 1'b0, 2'd1);
    // P1 with a press: the press is dropped
    drive(3'b010, 1'b0, 1'b0); tick();
    drive(3'b100, 1'b1, 1'b0); tick();
    chk_all("p1_press", 3'b000, 1'b1, 1'b0, 1'b0, 2'd2);

    // reset in the middle of a lockout
    drive(3'b001, 1'b0, 1'b0); tick();
    drive(3'b000, 1'b1, 1'b0); tick();
    chk_all("mid_lock_enter", 3'b000, 1'b1, 1'b0, 1'b1, 2'd3);
    drive(3'b000, 1'b0, 1'b0); tick(); tick();
    chk_all("mid_lock_hold", 3'b000, 1'b0, 1'b0, 1'b1, 2'd3);
    RST = 1'b1; tick();
    chk_all("mid_lock_rst", 3'b000, 1'b0, 1'b0, 1'b0, 2'd0);
`ifdef PASSCODE_ALARM_EN
    chk("mid_lock_rst.Alarm", {7'd0, Alarm}, 8'd0);
`endif
    RST = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk_all("post_rst_idle", 3'b000, 1'b0, 1'b0, 1'b0, 2'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
